slow_tick_timer: RTL and testbench
==================================

// Module: slow_tick_timer
// PURPOSE
//  Consumer end of the clock divider output. Takes the divided square wave clk_d
//  (a level toggling every div_value+1 fast cycles) back into the fast clock domain.
//  Synchronises it, edge-detects it into one-cycle tick pulses, and drives a
//  loadable, pausable countdown (game round timer, mole-up timer) that flags expiry.
// PARAMETERS
//  WIDTH        8   width of load_value / time_left
//  SYNC_STAGES  2   flip-flops in the clk_d synchroniser (>=2)
//  BOTH_EDGES   0   0: tick on clk_d rising edge only; 1: tick on both edges
// PORTS
//  clk         in   1      fast system clock; all logic on posedge clk
//  rst         in   1      synchronous, active-high reset
//  clk_d       in   1      divided square wave from the divider, treated as async level
//  load        in   1      load load_value into the counter (pulse)
//  load_value  in   WIDTH  countdown start value
//  start       in   1      begin or resume counting (pulse)
//  pause       in   1      freeze counting (pulse)
//  tick        out  1      one-cycle pulse per qualifying clk_d edge
//  time_left   out  WIDTH  current count
//  running     out  1      high in RUN state
//  expired     out  1      one-cycle pulse when count reaches 0 in RUN
//  done        out  1      level, high in DONE state until next load
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - Synchroniser and edge registers = 0.
//   - State = IDLE, time_left = 0.
//   - tick, running, expired, done = 0.
//   - primed = 0.
//  Tick path:
//   - clk_d goes through SYNC_STAGES flops to give s, then one more flop to give s_prev.
//   - tick = primed & s & ~s_prev. With BOTH_EDGES=1: tick = primed & (s ^ s_prev).
//   - tick is registered. Latency is SYNC_STAGES+1 clk cycles from the first posedge clk
//     that samples the new clk_d level.
//   - primed is set one cycle after reset release. This suppresses a false edge if
//     clk_d=1 at reset.
//   - tick runs in every state; it is not gated by the FSM.
//  FSM states: IDLE, RUN, PAUSED, DONE.
//   - Priority each cycle: rst > load > pause > start > tick.
//   - load, any state:
//     time_left <= load_value; next state IDLE. A load in RUN or PAUSED aborts the
//     round; no expired pulse.
//   - IDLE + start:
//     time_left != 0 -> RUN. time_left == 0 -> stay IDLE (start ignored).
//   - RUN + pause -> PAUSED. A tick in the same cycle is dropped (no decrement).
//   - RUN + tick:
//     - time_left > 1: time_left <= time_left - 1.
//     - time_left == 1: time_left <= 0, next state DONE, expired = 1 for exactly
//       the next cycle (aligned with time_left == 0 and done rising).
//   - PAUSED: ticks ignored. start -> RUN. pause is a no-op.
//   - DONE: done = 1, time_left = 0, start and pause ignored. Leave only via load or rst.
//  Outputs:
//   - running = (state == RUN); done = (state == DONE). Both registered.
//   - time_left never wraps below 0. Arithmetic is unsigned WIDTH bits.
//   - load_value = 2^WIDTH-1 is legal.
//  Reset mid-round: returns to IDLE with time_left = 0. No expired pulse.
// TESTING
//  T1: clk_d toggles every 10 clk, BOTH_EDGES=0 -> tick every 20 clk, each 1 cycle wide,
//      first tick 3 clk after the first sampled rising edge (SYNC_STAGES=2).
//  T2: rst released with clk_d held 1 -> no tick until the next 0->1 transition of clk_d.
//  T3: load 3, start, 3 ticks -> time_left 3,2,1,0; expired pulse once; done=1;
//      running=0; further ticks leave time_left at 0.
//  T4: load 5, start, 2 ticks, pause on the same cycle as the 3rd tick -> time_left
//      stays 3. 4 ticks while PAUSED -> still 3. start, then 3 ticks -> DONE.
//  T5: load and start in the same cycle with load_value=4 -> IDLE, time_left=4.
//      start with time_left=0 -> stays IDLE.
//  T6: in RUN at time_left=2, load 9 -> IDLE, time_left=9, no expired.
//      rst in RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/slow_tick_timer.sv
// slow_tick_timer: synchronises the divided clock clk_d into the fast domain,
// turns its edges into one-cycle ticks and drives a loadable, pausable countdown.
// Ports: clk, rst (sync, active-high), clk_d (async level), load/load_value,
//   start, pause in; tick, time_left, running, expired (pulse), done (level) out.
module slow_tick_timer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BOTH_EDGES  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_d,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic             tick,
  output logic [WIDTH-1:0] time_left,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   primed;
  logic                   edge_hit;

  state_t                 state;
  state_t                 state_nx;
  logic [WIDTH-1:0]       time_nx;
  logic                   exp_nx;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    edge_hit = 1'b0;
    if (BOTH_EDGES != 0) edge_hit = s ^ s_prev;
    else                 edge_hit = s & ~s_prev;
  end

  // The first cycle after reset preloads the whole chain and s_prev with the
  // current clk_d level, so a clk_d that is already high is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      s_prev <= 1'b0;
      primed <= 1'b0;
      tick   <= 1'b0;
    end else if (!primed) begin
      sync   <= {SYNC_STAGES{clk_d}};
      s_prev <= clk_d;
      primed <= 1'b1;
      tick   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], clk_d};
      s_prev <= s;
      tick   <= edge_hit;
    end
  end

  always_comb begin
    state_nx = state;
    time_nx  = time_left;
    exp_nx   = 1'b0;
    if (load) begin
      state_nx = IDLE;
      time_nx  = load_value;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && time_left != '0) state_nx = RUN;
        end
        RUN: begin
          if (pause) begin
            state_nx = PAUSED;
          end else if (tick) begin
            if (time_left > ONE) begin
              time_nx = time_left - ONE;
            end else begin
              time_nx  = '0;
              state_nx = DONE;
              exp_nx   = (time_left == ONE);
            end
          end
        end
        PAUSED: begin
          if (start) state_nx = RUN;
        end
        DONE: begin
          time_nx = '0;
        end
        default: begin
          state_nx = IDLE;
          time_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      time_left <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nx;
      time_left <= time_nx;
      running   <= (state_nx == RUN);
      done      <= (state_nx == DONE);
      expired   <= exp_nx;
    end
  end

endmodule

// File: tb/tb_slow_tick_timer.sv
// tb_slow_tick_timer: directed stimulus for slow_tick_timer with
// hand-computed expectations checked by immediate assertions.
module tb_slow_tick_timer;

  logic       clk;
  logic       rst;
  logic       clk_d;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] time_left;
  logic       running;
  logic       expired;
  logic       done;

  int vectors;
  int miscompares;
  int nticks;

  slow_tick_timer #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .BOTH_EDGES (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_d     (clk_d),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .pause     (pause),
    .tick      (tick),
    .time_left (time_left),
    .running   (running),
    .expired   (expired),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rising clk_d edge; returns right after the posedge that consumed
  // the tick, with clk_d driven back low.
  task automatic do_tick(input logic pz);
    cyc(3);
    clk_d = 1'b1;
    cyc(2);
    check("tick_early", int'(tick), 0);
    cyc(1);
    check("tick_pulse", int'(tick), 1);
    pause = pz;
    cyc(1);
    pause = 1'b0;
    clk_d = 1'b0;
    check("tick_width", int'(tick), 0);
  endtask

  task automatic do_load(input int v);
    load       = 1'b1;
    load_value = 8'(v);
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nticks      = 0;
    rst         = 1'b1;
    clk_d       = 1'b1;
    load        = 1'b0;
    load_value  = '0;
    start       = 1'b0;
    pause       = 1'b0;
    cyc(3);
    check("rst_tick", int'(tick), 0);
    check("rst_time", int'(time_left), 0);
    check("rst_running", int'(running), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_done", int'(done), 0);

    // clk_d held high across reset release: no tick
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("t2_no_tick_high", int'(tick), 0);
    end
    clk_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check("t2_no_tick_fall", int'(tick), 0);
    end

    // free-running clk_d, toggle every 10 cycles
    for (int k = 0; k < 80; k++) begin
      check("t1_tick", int'(tick), (k % 20 == 3) ? 1 : 0);
      if (tick) nticks++;
      if (k % 10 == 0) clk_d = ~clk_d;
      cyc(1);
    end
    check("t1_tick_count", nticks, 4);
    cyc(4);

    // load 3, run to expiry
    do_load(3);
    check("t3_load", int'(time_left), 3);
    check("t3_idle", int'(running), 0);
    do_start();
    check("t3_running", int'(running), 1);
    check("t3_time3", int'(time_left), 3);
    do_tick(1'b0);
    check("t3_time2", int'(time_left), 2);
    do_tick(1'b0);
    check("t3_time1", int'(time_left), 1);
    check("t3_no_exp", int'(expired), 0);
    do_tick(1'b0);
    check("t3_time0", int'(time_left), 0);
    check("t3_expired", int'(expired), 1);
    check("t3_done", int'(done), 1);
    check("t3_stopped", int'(running), 0);
    cyc(1);
    check("t3_exp_once", int'(expired), 0);
    check("t3_done_lvl", int'(done), 1);
    do_tick(1'b0);
    check("t3_hold0", int'(time_left), 0);
    check("t3_no_exp2", int'(expired), 0);
    do_start();
    check("t3_done_start", int'(done), 1);

    // pause on the third tick
    do_load(5);
    check("t4_done_clr", int'(done), 0);
    check("t4_load", int'(time_left), 5);
    do_start();
    do_tick(1'b0);
    check("t4_time4", int'(time_left), 4);
    do_tick(1'b0);
    check("t4_time3", int'(time_left), 3);
    do_tick(1'b1);
    check("t4_pause_drop", int'(time_left), 3);
    check("t4_paused", int'(running), 0);
    for (int k = 0; k < 4; k++) begin
      do_tick(1'b0);
      check("t4_paused_hold", int'(time_left), 3);
    end
    do_start();
    check("t4_resume", int'(running), 1);
    do_tick(1'b0);
    check("t4_r2", int'(time_left), 2);
    do_tick(1'b0);
    check("t4_r1", int'(time_left), 1);
    do_tick(1'b0);
    check("t4_r0", int'(time_left), 0);
    check("t4_expired", int'(expired), 1);
    check("t4_done", int'(done), 1);

    // load and start together: load wins
    load       = 1'b1;
    start      = 1'b1;
    load_value = 8'd4;
    cyc(1);
    load  = 1'b0;
    start = 1'b0;
    check("t5_time4", int'(time_left), 4);
    check("t5_idle", int'(running), 0);
    check("t5_done_clr", int'(done), 0);
    do_load(0);
    do_start();
    check("t5_zero_idle", int'(running), 0);
    check("t5_zero_time", int'(time_left), 0);
    do_load(255);
    check("t5_max", int'(time_left), 255);
    do_tick(1'b0);
    check("t5_idle_tick", int'(time_left), 255);

    // abort by load, then reset mid-round
    do_load(3);
    do_start();
    do_tick(1'b0);
    check("t6_time2", int'(time_left), 2);
    do_load(9);
    check("t6_reload", int'(time_left), 9);
    check("t6_idle", int'(running), 0);
    check("t6_no_exp", int'(expired), 0);
    cyc(1);
    check("t6_no_exp2", int'(expired), 0);
    do_start();
    check("t6_run", int'(running), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_rst_time", int'(time_left), 0);
    check("t6_rst_run", int'(running), 0);
    check("t6_rst_exp", int'(expired), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_tick", int'(tick), 0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
